systolic_seq_ctrl: RTL and testbench

Sequencer for the 4x4 output-stationary `systolic_array`. It holds one 4x4 A tile and one 4x4 B tile in local buffers, loaded word by word. On `start` it clears the array accumulators, then streams A rows and B columns into the array edges with the required diagonal skew, zero-padded. After the array drains, it snapshots all 16 accumulators into a readable result bank and pulses `done`. It sits between the host/DMA side and the array, which it owns exclusively.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_skew_feeder.sv | 44 ++++
 rtl/systolic_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and buffer index helper for the 4x4 systolic sequencer.
package systolic_pkg;

  localparam int unsigned N           = 4;
  localparam int unsigned FEED_CYCLES = 3 * N - 2;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_ACC_W   = 32;
  localparam int unsigned K_W         = 4;
  localparam int unsigned IDX_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_CAPTURE,
    S_DONE
  } seq_state_t;

  // Flat element index for a row-major N x N tile.
  function automatic logic [IDX_W-1:0] idx(input int row, input int col);
    return IDX_W'(row * int'(N) + col);
  endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// Registered, diagonally skewed and zero-padded edge feed for the systolic array.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         feed,
  input  logic [K_W-1:0]               k,
  input  logic [N*N-1:0][DATA_W-1:0]   a_buf,
  input  logic [N*N-1:0][DATA_W-1:0]   b_buf,
  output logic [N-1:0][DATA_W-1:0]     a_out,
  output logic [N-1:0][DATA_W-1:0]     b_out
);

  logic [N-1:0][DATA_W-1:0] a_nxt;
  logic [N-1:0][DATA_W-1:0] b_nxt;

  // Row i of A (column j of B) enters i (j) steps late; out-of-range steps feed 0.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    if (feed) begin
      for (int i = 0; i < int'(N); i++) begin
        if (int'(k) >= i && int'(k) - i < int'(N)) begin
          a_nxt[i] = a_buf[idx(i, int'(k) - i)];
          b_nxt[i] = b_buf[idx(int'(k) - i, i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      a_out <= a_nxt;
      b_out <= b_nxt;
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for the 4x4 output-stationary systolic array: operand buffers, FSM, result bank.
// Optional SYSTOLIC_SEQ_ACC_EN adds acc_mode, which skips CLEAR to accumulate onto the array.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              start,
`ifdef SYSTOLIC_SEQ_ACC_EN
  input  logic              acc_mode,
`endif
  output logic              busy,
  output logic              done,
  input  logic [3:0]        rd_addr,
  output logic [ACC_W-1:0]  rd_data,
  output logic              arr_rst,
  output logic [DATA_W-1:0] arr_a0,
  output logic [DATA_W-1:0] arr_a1,
  output logic [DATA_W-1:0] arr_a2,
  output logic [DATA_W-1:0] arr_a3,
  output logic [DATA_W-1:0] arr_b0,
  output logic [DATA_W-1:0] arr_b1,
  output logic [DATA_W-1:0] arr_b2,
  output logic [DATA_W-1:0] arr_b3,
  input  logic [ACC_W-1:0]  arr_c0,
  input  logic [ACC_W-1:0]  arr_c1,
  input  logic [ACC_W-1:0]  arr_c2,
  input  logic [ACC_W-1:0]  arr_c3,
  input  logic [ACC_W-1:0]  arr_c4,
  input  logic [ACC_W-1:0]  arr_c5,
  input  logic [ACC_W-1:0]  arr_c6,
  input  logic [ACC_W-1:0]  arr_c7,
  input  logic [ACC_W-1:0]  arr_c8,
  input  logic [ACC_W-1:0]  arr_c9,
  input  logic [ACC_W-1:0]  arr_c10,
  input  logic [ACC_W-1:0]  arr_c11,
  input  logic [ACC_W-1:0]  arr_c12,
  input  logic [ACC_W-1:0]  arr_c13,
  input  logic [ACC_W-1:0]  arr_c14,
  input  logic [ACC_W-1:0]  arr_c15
);

  seq_state_t                 state_q, state_d;
  logic [K_W-1:0]             k_q, k_d;
  logic [N*N-1:0][DATA_W-1:0] a_buf_q, a_buf_d;
  logic [N*N-1:0][DATA_W-1:0] b_buf_q, b_buf_d;
  logic [N*N-1:0][ACC_W-1:0]  res_q;
  logic [N*N-1:0][ACC_W-1:0]  arr_c;
  logic [N-1:0][DATA_W-1:0]   feed_a;
  logic [N-1:0][DATA_W-1:0]   feed_b;
  logic                       skip_clear;

`ifdef SYSTOLIC_SEQ_ACC_EN
  assign skip_clear = acc_mode;
`else
  assign skip_clear = 1'b0;
`endif

  assign arr_c = {arr_c15, arr_c14, arr_c13, arr_c12, arr_c11, arr_c10, arr_c9, arr_c8,
                  arr_c7,  arr_c6,  arr_c5,  arr_c4,  arr_c3,  arr_c2,  arr_c1, arr_c0};

  // Next-state and step counter.
  always_comb begin
    state_d = state_q;
    k_d     = '0;
    unique case (state_q)
      S_IDLE:    if (start) state_d = skip_clear ? S_FEED : S_CLEAR;
      S_CLEAR:   state_d = S_FEED;
      S_FEED: begin
        if (k_q == K_W'(FEED_CYCLES - 1)) state_d = S_CAPTURE;
        else                              k_d     = k_q + K_W'(1);
      end
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Buffer write view; the feeder sees it too so a write landing with start is used by that run.
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (wr_en && wr_ready) begin
      if (wr_sel) b_buf_d[wr_addr] = wr_data;
      else        a_buf_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_ready <= 1'b1;
      a_buf_q  <= '0;
      b_buf_q  <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
      wr_ready <= (state_d == S_IDLE);
      a_buf_q  <= a_buf_d;
      b_buf_q  <= b_buf_d;
      if (state_q == S_CAPTURE) res_q <= arr_c;
    end
  end

  assign rd_data = res_q[rd_addr];
  assign arr_rst = rst | (state_q == S_CLEAR);

  systolic_skew_feeder #(
    .DATA_W (DATA_W)
  ) u_feeder (
    .clk   (clk),
    .rst   (rst),
    .feed  (state_d == S_FEED),
    .k     (k_d),
    .a_buf (a_buf_d),
    .b_buf (b_buf_d),
    .a_out (feed_a),
    .b_out (feed_b)
  );

  assign arr_a0 = feed_a[0];
  assign arr_a1 = feed_a[1];
  assign arr_a2 = feed_a[2];
  assign arr_a3 = feed_a[3];
  assign arr_b0 = feed_b[0];
  assign arr_b1 = feed_b[1];
  assign arr_b2 = feed_b[2];
  assign arr_b3 = feed_b[3];

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural 4x4 output-stationary array attached.
module tb_systolic_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_sel, start;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_ready, busy, done, arr_rst;
  logic [31:0] rd_data;
  logic [15:0] arr_a0, arr_a1, arr_a2, arr_a3, arr_b0, arr_b1, arr_b2, arr_b3;
  logic [31:0] arr_c0, arr_c1, arr_c2, arr_c3, arr_c4, arr_c5, arr_c6, arr_c7;
  logic [31:0] arr_c8, arr_c9, arr_c10, arr_c11, arr_c12, arr_c13, arr_c14, arr_c15;
`ifdef SYSTOLIC_SEQ_ACC_EN
  logic        acc_mode;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] ref_a [16];
  logic [15:0] ref_b [16];

  always #5 clk = ~clk;

  systolic_seq_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .start(start),
`ifdef SYSTOLIC_SEQ_ACC_EN
    .acc_mode(acc_mode),
`endif
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data), .arr_rst(arr_rst),
    .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_a3(arr_a3),
    .arr_b0(arr_b0), .arr_b1(arr_b1), .arr_b2(arr_b2), .arr_b3(arr_b3),
    .arr_c0(arr_c0), .arr_c1(arr_c1), .arr_c2(arr_c2), .arr_c3(arr_c3),
    .arr_c4(arr_c4), .arr_c5(arr_c5), .arr_c6(arr_c6), .arr_c7(arr_c7),
    .arr_c8(arr_c8), .arr_c9(arr_c9), .arr_c10(arr_c10), .arr_c11(arr_c11),
    .arr_c12(arr_c12), .arr_c13(arr_c13), .arr_c14(arr_c14), .arr_c15(arr_c15)
  );

  // Behavioural array: a moves right, b moves down, each PE accumulates a*b.
  logic [15:0] ta [4];
  logic [15:0] tbv [4];
  logic [15:0] pa [4][4];
  logic [15:0] pb [4][4];
  logic [15:0] ain [4][4];
  logic [15:0] bin [4][4];
  logic [31:0] pc [4][4];

  always_comb begin
    ta[0] = arr_a0; ta[1] = arr_a1; ta[2] = arr_a2; ta[3] = arr_a3;
    tbv[0] = arr_b0; tbv[1] = arr_b1; tbv[2] = arr_b2; tbv[3] = arr_b3;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ain[i][j] = (j == 0) ? ta[i]  : pa[i][(j + 3) % 4];
        bin[i][j] = (i == 0) ? tbv[j] : pb[(i + 3) % 4][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (arr_rst) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          pc[i][j] <= '0;
        end else begin
          pa[i][j] <= ain[i][j];
          pb[i][j] <= bin[i][j];
          pc[i][j] <= pc[i][j] + 32'(ain[i][j]) * 32'(bin[i][j]);
        end
      end
    end
  end

  assign arr_c0  = pc[0][0]; assign arr_c1  = pc[0][1]; assign arr_c2  = pc[0][2]; assign arr_c3  = pc[0][3];
  assign arr_c4  = pc[1][0]; assign arr_c5  = pc[1][1]; assign arr_c6  = pc[1][2]; assign arr_c7  = pc[1][3];
  assign arr_c8  = pc[2][0]; assign arr_c9  = pc[2][1]; assign arr_c10 = pc[2][2]; assign arr_c11 = pc[2][3];
  assign arr_c12 = pc[3][0]; assign arr_c13 = pc[3][1]; assign arr_c14 = pc[3][2]; assign arr_c15 = pc[3][3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic sel, input int addr, input logic [15:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    if (sel) ref_b[addr] = data;
    else     ref_a[addr] = data;
  endtask

  task automatic load_identity(input logic sel);
    for (int e = 0; e < 16; e++) write(sel, e, (e / 4 == e % 4) ? 16'd1 : 16'd0);
  endtask

  task automatic load_seq_b();
    for (int e = 0; e < 16; e++) write(1'b1, e, 16'(e + 1));
  endtask

  task automatic load_const(input logic sel, input logic [15:0] v);
    for (int e = 0; e < 16; e++) write(sel, e, v);
  endtask

  task automatic read_res(input int a, output logic [31:0] v);
    rd_addr = 4'(a);
    #1;
    v = rd_data;
  endtask

  function automatic logic [31:0] model_c(input int i, input int j);
    logic [31:0] s = 32'd0;
    for (int m = 0; m < 4; m++) s += 32'(ref_a[i * 4 + m]) * 32'(ref_b[m * 4 + j]);
    return s;
  endfunction

  task automatic check_results(input string tag);
    logic [31:0] v;
    for (int e = 0; e < 16; e++) begin
      read_res(e, v);
      check($sformatf("%s[%0d]", tag, e), v, model_c(e / 4, e % 4));
    end
  endtask

  // Pulse start in the current cycle (cycle 0) and measure the cycle in which done appears.
  task automatic run(input string tag, input logic acc, input int exp_lat);
    int cyc;
`ifdef SYSTOLIC_SEQ_ACC_EN
    acc_mode = acc;
`else
    if (acc) $display("note: accumulate mode not built in");
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_lat));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
`ifdef SYSTOLIC_SEQ_ACC_EN
    acc_mode = 1'b0;
`endif
  endtask

  initial begin
    logic [31:0] v;
    int dones;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; rd_addr = '0;
`ifdef SYSTOLIC_SEQ_ACC_EN
    acc_mode = 1'b0;
`endif
    for (int e = 0; e < 16; e++) begin ref_a[e] = '0; ref_b[e] = '0; end

    // Reset state
    repeat (3) tick();
    check("rst_arr_rst", 32'(arr_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_arr_a0", 32'(arr_a0), 32'd0);
    check("rst_arr_b3", 32'(arr_b3), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_arr_rst", 32'(arr_rst), 32'd0);
    read_res(5, v);
    check("rst_res5", v, 32'd0);

    // Identity times sequential B
    load_identity(1'b0);
    load_seq_b();
    run("ident", 1'b0, 13);
    check_results("ident");
    read_res(15, v);
    check("ident_res15", v, 32'd16);

    // All ones at full width: wrap of 4*0xFFFE0001
    load_const(1'b0, 16'hFFFF);
    load_const(1'b1, 16'hFFFF);
    run("wrap", 1'b0, 13);
    for (int e = 0; e < 16; e += 5) begin
      read_res(e, v);
      check($sformatf("wrap_res%0d", e), v, 32'hFFF80004);
    end

    // Reset in cycle 6 (mid-FEED) aborts the run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_arr_rst", 32'(arr_rst), 32'd1);
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    for (int e = 0; e < 16; e++) begin ref_a[e] = '0; ref_b[e] = '0; end
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dones++;
      tick();
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd1);
    check_results("abort_zero");
    load_identity(1'b0);
    load_seq_b();
    run("rerun", 1'b0, 13);
    check_results("rerun");

    // Write and start while busy are both dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("busy_wr_ready", 32'(wr_ready), 32'd0);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'd7; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      tick();
    end
    check("busy_one_done", 32'(dones), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    run("busy_after", 1'b0, 13);
    read_res(0, v);
    check("busy_buf_a0", v, 32'd1);
    check_results("busy_after");

    // Write of A[5]=3 in the start cycle is used by that run; second run is back-to-back
    load_const(1'b1, 16'd1);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 16'd3;
    ref_a[5] = 16'd3;
    run("samecyc", 1'b0, 13);
    run("b2b", 1'b0, 13);
    read_res(4, v);
    check("samecyc_row1", v, 32'd3);
    read_res(0, v);
    check("samecyc_row0", v, 32'd1);
    check_results("samecyc");

`ifdef SYSTOLIC_SEQ_ACC_EN
    // Accumulate mode: identity*identity twice
    load_identity(1'b0);
    load_identity(1'b1);
    run("acc0", 1'b0, 13);
    run("acc1", 1'b1, 12);
    for (int e = 0; e < 16; e++) begin
      read_res(e, v);
      check($sformatf("acc_res%0d", e), v, (e / 4 == e % 4) ? 32'd2 : 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
